// File: rtl/round_controller.sv
// rtl/round_controller.sv - per-round referee: crash scoring, freeze timing, round/match advance (optional ROUND_TIMEOUT_EN round timer)
module round_controller #(
    parameter int WIN_SCORE            = 3,
    parameter int FREEZE_FRAMES        = 120,
    parameter int ROUND_TIMEOUT_FRAMES = 3600
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Reset_Game,
    input  logic [2:0] Game_State,
    input  logic       frame_tick,
    input  logic       Blue_Crash,
    input  logic       Red_Crash,
    output logic [1:0] Score_B,
    output logic [1:0] Score_R,
    output logic       Blue_W,
    output logic       Red_W,
    output logic       Reset_Round,
    output logic       freeze,
    output logic [1:0] round_winner
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_FREEZE  = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_MATCH   = 3'd4;

    localparam logic [2:0] GS_MENU    = 3'd0;
    localparam logic [2:0] GS_STARTED = 3'd2;

    localparam logic [1:0] WIN       = 2'(WIN_SCORE);
    localparam logic [7:0] FRZ_LOAD  = 8'(FREEZE_FRAMES);

`ifdef ROUND_TIMEOUT_EN
    localparam int         TO_W    = $clog2(ROUND_TIMEOUT_FRAMES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ROUND_TIMEOUT_FRAMES);
    logic [TO_W-1:0] to_cnt;
`endif

    logic [2:0] state;
    logic [7:0] frz_cnt;
    logic       any_crash;

    assign any_crash = Blue_Crash | Red_Crash;

    // Next-round pulse is decoded straight from ADVANCE so an async reset kills it at once
    // and it can never coincide with a match win (that path sets Blue_W/Red_W instead).
    assign Reset_Round = (state == S_ADVANCE) && (Score_B != WIN) && (Score_R != WIN);

    // Round referee state machine with score, winner and freeze registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            frz_cnt      <= '0;
            Score_B      <= '0;
            Score_R      <= '0;
            Blue_W       <= 1'b0;
            Red_W        <= 1'b0;
            freeze       <= 1'b0;
            round_winner <= '0;
`ifdef ROUND_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else if (Reset_Game) begin
            state        <= S_IDLE;
            frz_cnt      <= '0;
            Score_B      <= '0;
            Score_R      <= '0;
            Blue_W       <= 1'b0;
            Red_W        <= 1'b0;
            freeze       <= 1'b0;
            round_winner <= '0;
`ifdef ROUND_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Game_State == GS_MENU) begin
                        Score_B      <= '0;
                        Score_R      <= '0;
                        round_winner <= '0;
                    end
                    if (Game_State == GS_STARTED) begin
                        state <= S_PLAY;
`ifdef ROUND_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                S_PLAY: begin
                    if (any_crash) begin
                        // Blue crashing scores for red and vice versa; both at once is a draw.
                        case ({Blue_Crash, Red_Crash})
                            2'b10: begin
                                if (Score_R != WIN) Score_R <= Score_R + 2'd1;
                                round_winner <= 2'd2;
                            end
                            2'b01: begin
                                if (Score_B != WIN) Score_B <= Score_B + 2'd1;
                                round_winner <= 2'd1;
                            end
                            default: round_winner <= 2'd3;
                        endcase
                        frz_cnt <= FRZ_LOAD;
                        freeze  <= 1'b1;
                        state   <= S_FREEZE;
                    end else if (Game_State != GS_STARTED) begin
                        state <= S_IDLE;
                    end
`ifdef ROUND_TIMEOUT_EN
                    else if (frame_tick) begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt + 1'b1 == TO_LAST) begin
                            round_winner <= 2'd3;
                            frz_cnt      <= FRZ_LOAD;
                            freeze       <= 1'b1;
                            state        <= S_FREEZE;
                        end
                    end
`endif
                end
                S_FREEZE: begin
                    if (frame_tick) begin
                        frz_cnt <= frz_cnt - 8'd1;
                        if (frz_cnt <= 8'd1) state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (Score_B == WIN) begin
                        Blue_W <= 1'b1;
                        state  <= S_MATCH;
                    end else if (Score_R == WIN) begin
                        Red_W <= 1'b1;
                        state <= S_MATCH;
                    end else begin
                        freeze <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_MATCH: begin
                    if (Game_State == GS_MENU) begin
                        Score_B      <= '0;
                        Score_R      <= '0;
                        Blue_W       <= 1'b0;
                        Red_W        <= 1'b0;
                        round_winner <= '0;
                        freeze       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller
module tb_round_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Reset_Game = 1'b0;
    logic [2:0] Game_State = 3'd1;
    logic       frame_tick = 1'b0;
    logic       Blue_Crash = 1'b0;
    logic       Red_Crash = 1'b0;
    logic [1:0] Score_B;
    logic [1:0] Score_R;
    logic       Blue_W;
    logic       Red_W;
    logic       Reset_Round;
    logic       freeze;
    logic [1:0] round_winner;

    int checks = 0;
    int fails  = 0;

    round_controller #(
        .WIN_SCORE(3),
        .FREEZE_FRAMES(2),
        .ROUND_TIMEOUT_FRAMES(5)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Reset_Game(Reset_Game),
        .Game_State(Game_State),
        .frame_tick(frame_tick),
        .Blue_Crash(Blue_Crash),
        .Red_Crash(Red_Crash),
        .Score_B(Score_B),
        .Score_R(Score_R),
        .Blue_W(Blue_W),
        .Red_W(Red_W),
        .Reset_Round(Reset_Round),
        .freeze(freeze),
        .round_winner(round_winner)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    // Full round from IDLE: start, crash for one cycle, two freeze ticks, leave ADVANCE.
    task automatic play_round(input logic b, input logic r);
        Game_State = 3'd2;
        step(1);
        Blue_Crash = b;
        Red_Crash  = r;
        step(1);
        Blue_Crash = 1'b0;
        Red_Crash  = 1'b0;
        tick();
        tick();
        Game_State = 3'd1;
        step(1);
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (Score_B !== 2'd0)      begin fails++; $display("FAIL reset_score_b got %0d want 0", Score_B); end
        checks++; if (Score_R !== 2'd0)      begin fails++; $display("FAIL reset_score_r got %0d want 0", Score_R); end
        checks++; if (Blue_W !== 1'b0)       begin fails++; $display("FAIL reset_blue_w got %b want 0", Blue_W); end
        checks++; if (Red_W !== 1'b0)        begin fails++; $display("FAIL reset_red_w got %b want 0", Red_W); end
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL reset_reset_round got %b want 0", Reset_Round); end
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL reset_freeze got %b want 0", freeze); end
        checks++; if (round_winner !== 2'd0) begin fails++; $display("FAIL reset_round_winner got %0d want 0", round_winner); end
        Reset = 1'b0;
        step(1);
    endtask

    task automatic test_red_round();
        Game_State = 3'd2;
        step(1);
        Red_Crash = 1'b1;
        step(1);
        Red_Crash = 1'b0;
        checks++; if (Score_B !== 2'd1)      begin fails++; $display("FAIL red_score_b got %0d want 1", Score_B); end
        checks++; if (Score_R !== 2'd0)      begin fails++; $display("FAIL red_score_r got %0d want 0", Score_R); end
        checks++; if (round_winner !== 2'd1) begin fails++; $display("FAIL red_winner got %0d want 1", round_winner); end
        checks++; if (freeze !== 1'b1)       begin fails++; $display("FAIL red_freeze got %b want 1", freeze); end
        tick();
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL red_early_rr got %b want 0", Reset_Round); end
        checks++; if (freeze !== 1'b1)       begin fails++; $display("FAIL red_freeze_mid got %b want 1", freeze); end
        tick();
        checks++; if (Reset_Round !== 1'b1)  begin fails++; $display("FAIL red_rr_pulse got %b want 1", Reset_Round); end
        Game_State = 3'd1;
        step(1);
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL red_rr_end got %b want 0", Reset_Round); end
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL red_freeze_end got %b want 0", freeze); end
    endtask

    task automatic test_draw();
        Game_State = 3'd2;
        step(1);
        Blue_Crash = 1'b1;
        Red_Crash  = 1'b1;
        step(1);
        Blue_Crash = 1'b0;
        Red_Crash  = 1'b0;
        checks++; if (round_winner !== 2'd3) begin fails++; $display("FAIL draw_winner got %0d want 3", round_winner); end
        checks++; if (Score_B !== 2'd1)      begin fails++; $display("FAIL draw_score_b got %0d want 1", Score_B); end
        checks++; if (Score_R !== 2'd0)      begin fails++; $display("FAIL draw_score_r got %0d want 0", Score_R); end
        tick();
        tick();
        checks++; if (Reset_Round !== 1'b1)  begin fails++; $display("FAIL draw_rr got %b want 1", Reset_Round); end
        Game_State = 3'd1;
        step(1);
    endtask

    task automatic test_crash_held();
        Game_State = 3'd2;
        step(1);
        Blue_Crash = 1'b1;
        step(1);
        tick();
        tick();
        checks++; if (Score_R !== 2'd1)      begin fails++; $display("FAIL held_score_r got %0d want 1", Score_R); end
        checks++; if (Reset_Round !== 1'b1)  begin fails++; $display("FAIL held_rr got %b want 1", Reset_Round); end
        Blue_Crash = 1'b0;
        Game_State = 3'd1;
        step(1);
        checks++; if (Score_R !== 2'd1)      begin fails++; $display("FAIL held_score_r_after got %0d want 1", Score_R); end
        checks++; if (round_winner !== 2'd2) begin fails++; $display("FAIL held_winner got %0d want 2", round_winner); end
    endtask

    task automatic test_match_win();
        play_round(1'b0, 1'b1);
        checks++; if (Score_B !== 2'd2)      begin fails++; $display("FAIL match_score_b2 got %0d want 2", Score_B); end
        Game_State = 3'd2;
        step(1);
        Red_Crash = 1'b1;
        step(1);
        Red_Crash = 1'b0;
        tick();
        tick();
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL match_no_rr got %b want 0", Reset_Round); end
        Game_State = 3'd1;
        step(1);
        checks++; if (Score_B !== 2'd3)      begin fails++; $display("FAIL match_score_b3 got %0d want 3", Score_B); end
        checks++; if (Blue_W !== 1'b1)       begin fails++; $display("FAIL match_blue_w got %b want 1", Blue_W); end
        checks++; if (Red_W !== 1'b0)        begin fails++; $display("FAIL match_red_w got %b want 0", Red_W); end
        step(3);
        checks++; if (Blue_W !== 1'b1)       begin fails++; $display("FAIL match_blue_w_hold got %b want 1", Blue_W); end
        checks++; if (freeze !== 1'b1)       begin fails++; $display("FAIL match_freeze got %b want 1", freeze); end
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL match_rr_hold got %b want 0", Reset_Round); end
        Game_State = 3'd0;
        step(1);
        checks++; if (Score_B !== 2'd0)      begin fails++; $display("FAIL match_clear_b got %0d want 0", Score_B); end
        checks++; if (Score_R !== 2'd0)      begin fails++; $display("FAIL match_clear_r got %0d want 0", Score_R); end
        checks++; if (Blue_W !== 1'b0)       begin fails++; $display("FAIL match_clear_w got %b want 0", Blue_W); end
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL match_clear_freeze got %b want 0", freeze); end
        checks++; if (round_winner !== 2'd0) begin fails++; $display("FAIL match_clear_winner got %0d want 0", round_winner); end
        Game_State = 3'd1;
        step(1);
    endtask

    task automatic test_clears();
        play_round(1'b0, 1'b1);
        Game_State = 3'd0;
        step(1);
        checks++; if (Score_B !== 2'd0)      begin fails++; $display("FAIL menu_clear_b got %0d want 0", Score_B); end
        checks++; if (round_winner !== 2'd0) begin fails++; $display("FAIL menu_clear_winner got %0d want 0", round_winner); end
        Game_State = 3'd1;
        play_round(1'b0, 1'b1);
        Reset_Game = 1'b1;
        step(1);
        Reset_Game = 1'b0;
        checks++; if (Score_B !== 2'd0)      begin fails++; $display("FAIL reset_game_b got %0d want 0", Score_B); end
        checks++; if (round_winner !== 2'd0) begin fails++; $display("FAIL reset_game_winner got %0d want 0", round_winner); end
    endtask

    task automatic test_reset_mid_freeze();
        play_round(1'b1, 1'b0);
        Game_State = 3'd2;
        step(1);
        Blue_Crash = 1'b1;
        step(1);
        Blue_Crash = 1'b0;
        Game_State = 3'd1;
        checks++; if (Score_R !== 2'd2)      begin fails++; $display("FAIL midfrz_score_r got %0d want 2", Score_R); end
        tick();
        Reset = 1'b1;
        #1;
        checks++; if (Score_R !== 2'd0)      begin fails++; $display("FAIL midfrz_async_r got %0d want 0", Score_R); end
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL midfrz_async_freeze got %b want 0", freeze); end
        checks++; if (round_winner !== 2'd0) begin fails++; $display("FAIL midfrz_async_winner got %0d want 0", round_winner); end
        step(1);
        Reset = 1'b0;
        tick();
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL midfrz_rr1 got %b want 0", Reset_Round); end
        tick();
        checks++; if (Reset_Round !== 1'b0)  begin fails++; $display("FAIL midfrz_rr2 got %b want 0", Reset_Round); end
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL midfrz_freeze_after got %b want 0", freeze); end
    endtask

`ifdef ROUND_TIMEOUT_EN
    task automatic test_timeout();
        Game_State = 3'd2;
        step(1);
        repeat (4) tick();
        checks++; if (freeze !== 1'b0)       begin fails++; $display("FAIL timeout_early got %b want 0", freeze); end
        tick();
        checks++; if (freeze !== 1'b1)       begin fails++; $display("FAIL timeout_freeze got %b want 1", freeze); end
        checks++; if (round_winner !== 2'd3) begin fails++; $display("FAIL timeout_winner got %0d want 3", round_winner); end
        checks++; if (Score_B !== 2'd0 || Score_R !== 2'd0) begin fails++; $display("FAIL timeout_scores got %0d/%0d want 0/0", Score_B, Score_R); end
        tick();
        tick();
        checks++; if (Reset_Round !== 1'b1)  begin fails++; $display("FAIL timeout_rr got %b want 1", Reset_Round); end
        Game_State = 3'd1;
        step(1);
    endtask
`endif

    initial begin
        test_reset();
        test_red_round();
        test_draw();
        test_crash_held();
        test_match_win();
        test_clears();
        test_reset_mid_freeze();
`ifdef ROUND_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
